tdm_tx: RTL
===========

Name: tdm_tx

Overview:
TDM serial transmitter and frame master for the audio output path. It pops PCM words from a first-word-fall-through (FWFT) FIFO and serialises them MSB-first on sd_out, one WORD_LEN-bit slot per channel, TDM_CHANNELS slots per frame. It generates the frame sync (lrclk) and bclk-domain status. Its framing is the mirror of the TDM receive path.

Parameters:
PCM_WIDTH, 24, PCM sample width; MSB-aligned in the slot, low WORD_LEN-PCM_WIDTH bits sent as 0.
WORD_LEN, 32, bclk cycles per slot; must be >= PCM_WIDTH.
TDM_CHANNELS, 8, slots per frame; must be >= 2.
DATA_DELAY, 0, 0 = lrclk high during bit 0 of slot 0; 1 = lrclk high one bclk earlier (last bit of previous frame).

Ports:
bclk  in  1  bit clock; all logic on posedge.
rst_n  in  1  reset, synchronous, active-low; clock bclk.
enable  in  1  run request.
slot_mask  in  TDM_CHANNELS  bit n = 1: slot n carries FIFO data; 0: slot sends zeros, no pop.
pcm_data  in  PCM_WIDTH  FIFO head word, valid when fifo_empty = 0.
fifo_empty  in  1  FIFO empty flag.
fifo_rd  out  1  pop strobe, combinational, one cycle per consumed word.
sd_out  out  1  serial data.
lrclk  out  1  frame sync, 1 bclk wide.
frame_start  out  1  1-cycle pulse while bit 0 of slot 0 is on sd_out.
slot_idx  out  clog2(TDM_CHANNELS)  slot currently on sd_out.
busy  out  1  state != IDLE.
underrun  out  1  sticky underrun flag.
underrun_clr  in  1  clears underrun.

Behaviour:
- Reset (rst_n = 0 at posedge):
  - Registered outputs: sd_out = 0, lrclk = 0, frame_start = 0, slot_idx = 0, busy = 0, underrun = 0.
  - Internal: shift register = 0, bit_cnt = 0, state = IDLE.
  - fifo_rd = 0 while rst_n = 0.
  - Reset mid-frame aborts immediately; no partial-slot completion.
- States: IDLE, PRIME, RUN.
- IDLE:
  - sd_out = 0, lrclk = 0, counters held at 0.
  - enable = 1 -> PRIME.
- PRIME (exactly 1 cycle):
  - Performs the slot-0 load (see load rule).
  - If DATA_DELAY = 1, lrclk = 1 in the following cycle.
  - Next state: RUN with bit_cnt = 0, slot_idx = 0.
- RUN:
  - Each cycle: sd_out = shift_r MSB, shift_r shifts left with 0 fill, bit_cnt increments.
  - At bit_cnt = WORD_LEN-1: bit_cnt wraps to 0, slot_idx increments (wraps TDM_CHANNELS-1 -> 0), and the load for the next slot occurs.
- Load rule (PRIME cycle, or RUN with bit_cnt = WORD_LEN-1), for target slot s:
  - slot_mask[s] = 1 and fifo_empty = 0: shift_r <= {pcm_data, zero pad}; fifo_rd = 1 that cycle.
  - slot_mask[s] = 1 and fifo_empty = 1: shift_r <= 0; underrun set; no pop.
  - slot_mask[s] = 0: shift_r <= 0; no pop; not an underrun.
  - fifo_rd is never asserted outside a load cycle.
- Latency:
  - Word loaded in a load cycle appears (MSB) on sd_out on the next bclk.
  - From enable rising in IDLE: 1 cycle to PRIME, MSB of slot 0 two cycles after.
- lrclk:
  - DATA_DELAY = 0: high in the cycle bit 0 of slot 0 is on sd_out, coincident with frame_start.
  - DATA_DELAY = 1: high in the cycle the last bit of slot TDM_CHANNELS-1 is on sd_out, or the cycle after PRIME for the first frame.
- Stop:
  - enable = 0 during RUN completes the current frame through the last bit of slot TDM_CHANNELS-1.
  - At that final load point: no pop, no underrun, no lrclk; then IDLE.
  - enable reasserted before frame end cancels the stop.
- underrun:
  - Set and clear in the same cycle: set wins.
  - Held through IDLE until underrun_clr or reset.
- slot_mask is sampled only at load cycles; mid-slot changes affect the next load.

Test Plan:
- WORD_LEN=32, PCM_WIDTH=24, CH=8, FIFO preloaded 0x800001..0x800008, all slots enabled, enable=1 -> 8 pops exactly at load cycles; slot 0 bits = 0x80000100 MSB-first; lrclk/frame_start once per 256 bclk; underrun stays 0.
- FIFO holds 3 words, enable -> slots 0-2 carry data, slots 3-7 zeros, underrun = 1 at slot-3 load; underrun_clr -> 0; clr with coincident new underrun -> stays 1.
- slot_mask = 0x05, FIFO full -> pops only for slots 0 and 2 each frame; other slots zero; underrun = 0.
- enable dropped at slot 3 -> frame completes to slot 7 last bit, no 9th pop, busy falls, lrclk stays 0 afterward.
- DATA_DELAY=1 -> lrclk asserted exactly 1 bclk before frame_start every frame, including the first after PRIME.
- rst_n = 0 mid-slot 5 -> next cycle sd_out = 0, lrclk = 0, busy = 0, fifo_rd = 0, counters 0.

Source files
------------

// File: rtl/tdm_tx.sv
// ---------------------------------------------------------------------------
// tdm_tx : TDM serial transmitter and frame master for the audio output path.
//
// PCM words are popped from a first-word-fall-through FIFO and shifted out
// MSB-first on sd_out. Each slot is WORD_LEN bclk cycles long, and a frame
// has TDM_CHANNELS slots. The PCM word sits MSB-aligned in its slot and the
// unused low bits are sent as zero. The framing mirrors the TDM receive path.
//
// Ports
//   bclk          bit clock; all logic runs on its rising edge
//   rst_n         synchronous, active-low reset
//   enable        run request (dropping it finishes the current frame first)
//   slot_mask     bit n set: slot n carries FIFO data; clear: slot sends zeros
//   pcm_data      FIFO head word, valid while fifo_empty is low
//   fifo_empty    FIFO empty flag
//   fifo_rd       combinational pop strobe, one cycle per consumed word
//   sd_out        serial data, registered
//   lrclk         frame sync, one bclk wide, registered
//   frame_start   high while bit 0 of slot 0 is on sd_out
//   slot_idx      slot currently on sd_out
//   busy          high whenever the transmitter is not idle
//   underrun      sticky flag: a data-carrying slot found the FIFO empty
//   underrun_clr  clears underrun (a new underrun in the same cycle wins)
// ---------------------------------------------------------------------------
module tdm_tx #(
   parameter int PCM_WIDTH    = 24,
   parameter int WORD_LEN     = 32,
   parameter int TDM_CHANNELS = 8,
   parameter int DATA_DELAY   = 0
) (
   input  logic                            bclk,
   input  logic                            rst_n,
   input  logic                            enable,
   input  logic [TDM_CHANNELS-1:0]         slot_mask,
   input  logic [PCM_WIDTH-1:0]            pcm_data,
   input  logic                            fifo_empty,
   output logic                            fifo_rd,
   output logic                            sd_out,
   output logic                            lrclk,
   output logic                            frame_start,
   output logic [$clog2(TDM_CHANNELS)-1:0] slot_idx,
   output logic                            busy,
   output logic                            underrun,
   input  logic                            underrun_clr
);

   localparam int SLOT_W = $clog2(TDM_CHANNELS);
   localparam int BIT_W  = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;

   localparam logic [BIT_W-1:0]  LAST_BIT     = BIT_W'(WORD_LEN - 1);
   localparam logic [BIT_W-1:0]  PRE_LAST_BIT = BIT_W'(WORD_LEN - 2);
   localparam logic [SLOT_W-1:0] LAST_SLOT    = SLOT_W'(TDM_CHANNELS - 1);

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      RUN
   } state_t;

   state_t               state;
   logic [WORD_LEN-1:0]  shift_r;
   logic [BIT_W-1:0]     bit_cnt;

   logic [SLOT_W-1:0]    next_slot;
   logic [SLOT_W-1:0]    load_slot;
   logic                 frame_end;
   logic                 stopping;
   logic                 load_now;
   logic                 slot_on;
   logic                 take_word;
   logic                 underrun_set;
   logic [WORD_LEN-1:0]  load_word;

   // Load decision for the slot that follows the one currently on sd_out.
   // The last bit of a slot is on the line during the load cycle, so the
   // freshly loaded word's MSB appears on the very next bclk. When enable is
   // low at the final load point of a frame the load is skipped entirely:
   // no pop, no underrun, and the transmitter drops back to IDLE.
   always_comb begin
      next_slot    = (slot_idx == LAST_SLOT) ? '0 : slot_idx + 1'b1;
      frame_end    = (state == RUN) && (bit_cnt == LAST_BIT) && (slot_idx == LAST_SLOT);
      stopping     = frame_end && !enable;
      load_now     = (state == PRIME) || ((state == RUN) && (bit_cnt == LAST_BIT) && !stopping);
      load_slot    = (state == PRIME) ? '0 : next_slot;
      slot_on      = slot_mask[load_slot];
      take_word    = load_now && slot_on && !fifo_empty;
      underrun_set = load_now && slot_on && fifo_empty;
      fifo_rd      = rst_n && take_word;
      load_word    = take_word ? (WORD_LEN'(pcm_data) << (WORD_LEN - PCM_WIDTH)) : '0;
   end

   // Main sequencer. sd_out is registered: at a load edge it takes the MSB of
   // the new word directly and shift_r keeps the remaining bits, so shift_r
   // always runs one bit ahead of the line.
   // With DATA_DELAY = 1 lrclk leads frame_start by one bclk. For the first
   // frame that lead cycle is the PRIME cycle, so lrclk is raised on the
   // IDLE -> PRIME edge; in later frames it marks the last bit of the final slot.
   always_ff @(posedge bclk) begin
      if (!rst_n) begin
         state       <= IDLE;
         shift_r     <= '0;
         bit_cnt     <= '0;
         slot_idx    <= '0;
         sd_out      <= 1'b0;
         lrclk       <= 1'b0;
         frame_start <= 1'b0;
         busy        <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         lrclk       <= 1'b0;

         if (underrun_set) begin
            underrun <= 1'b1;
         end else if (underrun_clr) begin
            underrun <= 1'b0;
         end

         case (state)
            IDLE: begin
               sd_out   <= 1'b0;
               shift_r  <= '0;
               bit_cnt  <= '0;
               slot_idx <= '0;
               if (enable) begin
                  state <= PRIME;
                  busy  <= 1'b1;
                  lrclk <= (DATA_DELAY == 1);
               end
            end

            PRIME: begin
               sd_out      <= load_word[WORD_LEN-1];
               shift_r     <= load_word << 1;
               bit_cnt     <= '0;
               slot_idx    <= '0;
               state       <= RUN;
               frame_start <= 1'b1;
               lrclk       <= (DATA_DELAY == 0);
            end

            RUN: begin
               if (bit_cnt == LAST_BIT) begin
                  if (stopping) begin
                     state    <= IDLE;
                     busy     <= 1'b0;
                     sd_out   <= 1'b0;
                     shift_r  <= '0;
                     bit_cnt  <= '0;
                     slot_idx <= '0;
                  end else begin
                     sd_out   <= load_word[WORD_LEN-1];
                     shift_r  <= load_word << 1;
                     bit_cnt  <= '0;
                     slot_idx <= next_slot;
                     if (next_slot == '0) begin
                        frame_start <= 1'b1;
                        lrclk       <= (DATA_DELAY == 0);
                     end
                  end
               end else begin
                  sd_out  <= shift_r[WORD_LEN-1];
                  shift_r <= shift_r << 1;
                  bit_cnt <= bit_cnt + 1'b1;
                  if ((DATA_DELAY == 1) && (slot_idx == LAST_SLOT) &&
                      (bit_cnt == PRE_LAST_BIT) && enable) begin
                     lrclk <= 1'b1;
                  end
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
